systolic_mm_ctrl: RTL and testbench
===================================

Name: systolic_mm_ctrl

Overview:
- Sequencing controller for the 3x3 output-stationary systolic MAC array that computes C = A x B on 8-bit operands.
- Accepts a start request with both operand matrices, clears the array accumulators, and drives the skewed row/column feed sequence.
- Flushes the pipeline, captures the nine accumulator values and signals done.
- Sits between the host/register interface and the MAC array; owns all array timing.

Parameters:
DATA_W, 8, operand width per matrix element
ACC_W, 8, accumulator/result width per element (array wraps modulo 2^ACC_W)
DRAIN_CYCLES, 2, zero-feed cycles after the last feed step; must be >= 2 for a 3x3 array

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
a_flat  in  9*DATA_W  matrix A; a_rc at bits [DATA_W*(3r+c) +: DATA_W]
b_flat  in  9*DATA_W  matrix B, same packing
busy  out  1  high in CLEAR, FEED, DRAIN, CAPTURE
done  out  1  one-cycle pulse when results update
mac_clr  out  1  accumulator clear to all array cells
mac_en  out  1  accumulate enable to all cells
feed_a  out  3*DATA_W  row-edge inputs a0..a2 (a_i at [DATA_W*i +: DATA_W])
feed_b  out  3*DATA_W  column-edge inputs b0..b2, same packing
c_flat  in  9*ACC_W  array accumulators, cell (i,j) at [ACC_W*(3i+j) +: ACC_W]
result_flat  out  9*ACC_W  captured C, same packing as c_flat

Behaviour:
- Reset (reset=0 at rising edge, takes priority over everything): state=IDLE; busy, done, mac_clr, mac_en = 0; feed_a, feed_b, result_flat = 0; step counter = 0; latched operands = 0. Applies mid-operation: sequence aborts, no done pulse.
- All outputs are registered.
- Operands are latched into internal A/B registers on the edge that accepts start; later a_flat/b_flat changes do not affect the run in progress.
- States:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: 1 cycle; mac_clr=1, mac_en=0, feeds=0 -> FEED with step=0.
  - FEED: 5 cycles, step k=0..4; mac_en=1.
    - feed_a[i] = A[i][k-i] if 0<=k-i<=2, else 0.
    - feed_b[j] = B[k-j][j] if 0<=k-j<=2, else 0.
    - After k=4 -> DRAIN.
  - DRAIN: DRAIN_CYCLES cycles; feeds=0, mac_en=1 -> CAPTURE.
  - CAPTURE: 1 cycle; mac_en=0, feeds=0. result_flat <= c_flat at the end of this cycle -> DONE.
  - DONE: 1 cycle; done=1, busy=0. start=1 -> CLEAR (back-to-back accepted, new operands latched); else -> IDLE.
- Feed timing: values for step k appear on feed_a/feed_b during FEED cycle k. Array cell (i,j) consumes them in cycle k+i+j, so cell (2,2) takes its last term in step 6, the last DRAIN cycle at DRAIN_CYCLES=2.
- Latency: start sampled at edge E0 -> CLEAR in cycle 1, FEED in cycles 2-6, DRAIN in cycles 7-8, CAPTURE in cycle 9, done=1 in cycle 10. General form: done = 8 + DRAIN_CYCLES cycles after the accepting edge.
- start in CLEAR/FEED/DRAIN/CAPTURE is ignored; it is neither queued nor does it alter the run.
- result_flat holds its value until the next CAPTURE; it is not cleared by start.
- Arithmetic: the controller performs no arithmetic on results. Overflow is the array's modulo-2^ACC_W wrap, captured as-is.
- mac_clr and mac_en are never high in the same cycle.

Test Plan:
1. Reset, then start with A=[[1,2,3],[4,5,6],[7,8,9]] and B=identity -> done exactly 10 cycles after the start edge; result_flat = A; busy high cycles 1-9; one done pulse.
2. A all 2, B all 3 -> every result = 18. Check the feed trace: FEED step 2 gives feed_a=(a02,a11,a20)=(2,2,2) and feed_b=(b20,b11,b02)=(3,3,3). Step 0 gives feed_a=(2,0,0), feed_b=(3,0,0).
3. A all 16, B all 16 -> each result = 768 mod 256 = 0. Then rerun with A=B=identity -> result = identity, proving mac_clr wiped the prior accumulation.
4. Hold start=1 continuously with different operands for run 2 -> run 2 is accepted in the DONE cycle. Second done comes 10 cycles after the first; result updates; start pulses mid-run are ignored.
5. Assert reset=0 for one edge during FEED step 3 -> next cycle state IDLE, all feeds 0, busy=0, no done pulse. A subsequent start completes correctly.
6. Change a_flat/b_flat every cycle after start is accepted -> results match the operands latched at start.

Source files
------------

// File: rtl/systolic_mm_ctrl.sv
// Sequencing controller for a 3x3 output-stationary systolic MAC array.
// Latches A/B, clears the array, drives the skewed feeds, drains and captures C.
module systolic_mm_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ACC_W        = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9*DATA_W-1:0]   a_flat,
    input  logic [9*DATA_W-1:0]   b_flat,
    output logic                  busy,
    output logic                  done,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic [3*DATA_W-1:0]   feed_a,
    output logic [3*DATA_W-1:0]   feed_b,
    input  logic [9*ACC_W-1:0]    c_flat,
    output logic [9*ACC_W-1:0]    result_flat
);

    localparam int STEP_W = $clog2(DRAIN_CYCLES + 5);
    localparam logic [STEP_W-1:0] LAST_FEED  = STEP_W'(4);
    localparam logic [STEP_W-1:0] LAST_DRAIN = STEP_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_FEED    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t              state_r;
    logic [STEP_W-1:0]   step_r;
    logic [9*DATA_W-1:0] a_r;
    logic [9*DATA_W-1:0] b_r;

    // Row i enters the array skewed by i steps: a_i = A[i][k-i].
    function automatic logic [3*DATA_W-1:0] row_feed(input logic [9*DATA_W-1:0] m,
                                                     input logic [STEP_W-1:0]   k);
        logic [3*DATA_W-1:0] f;
        f = '0;
        for (int i = 0; i < 3; i++) begin
            if ((int'(k) >= i) && ((int'(k) - i) <= 2)) begin
                f[DATA_W*i +: DATA_W] = m[DATA_W*(3*i + int'(k) - i) +: DATA_W];
            end else begin
                f[DATA_W*i +: DATA_W] = '0;
            end
        end
        return f;
    endfunction

    // Column j enters the array skewed by j steps: b_j = B[k-j][j].
    function automatic logic [3*DATA_W-1:0] col_feed(input logic [9*DATA_W-1:0] m,
                                                     input logic [STEP_W-1:0]   k);
        logic [3*DATA_W-1:0] f;
        f = '0;
        for (int j = 0; j < 3; j++) begin
            if ((int'(k) >= j) && ((int'(k) - j) <= 2)) begin
                f[DATA_W*j +: DATA_W] = m[DATA_W*(3*(int'(k) - j) + j) +: DATA_W];
            end else begin
                f[DATA_W*j +: DATA_W] = '0;
            end
        end
        return f;
    endfunction

    // Sequencer: state, step counter, operand latches and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            step_r      <= '0;
            a_r         <= '0;
            b_r         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mac_clr     <= 1'b0;
            mac_en      <= 1'b0;
            feed_a      <= '0;
            feed_b      <= '0;
            result_flat <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done   <= 1'b0;
                    mac_en <= 1'b0;
                    feed_a <= '0;
                    feed_b <= '0;
                    step_r <= '0;
                    if (start) begin
                        a_r     <= a_flat;
                        b_r     <= b_flat;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                        state_r <= ST_CLEAR;
                    end else begin
                        busy    <= 1'b0;
                        mac_clr <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    mac_clr <= 1'b0;
                    mac_en  <= 1'b1;
                    step_r  <= '0;
                    feed_a  <= row_feed(a_r, '0);
                    feed_b  <= col_feed(b_r, '0);
                    state_r <= ST_FEED;
                end
                ST_FEED: begin
                    if (step_r == LAST_FEED) begin
                        step_r  <= '0;
                        feed_a  <= '0;
                        feed_b  <= '0;
                        state_r <= ST_DRAIN;
                    end else begin
                        step_r  <= step_r + STEP_W'(1);
                        feed_a  <= row_feed(a_r, step_r + STEP_W'(1));
                        feed_b  <= col_feed(b_r, step_r + STEP_W'(1));
                        state_r <= ST_FEED;
                    end
                end
                ST_DRAIN: begin
                    // The last drain cycle is when cell (2,2) takes its final term.
                    if (step_r == LAST_DRAIN) begin
                        step_r  <= '0;
                        mac_en  <= 1'b0;
                        state_r <= ST_CAPTURE;
                    end else begin
                        step_r  <= step_r + STEP_W'(1);
                        state_r <= ST_DRAIN;
                    end
                end
                ST_CAPTURE: begin
                    result_flat <= c_flat;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state_r     <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    step_r  <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    mac_clr <= 1'b0;
                    mac_en  <= 1'b0;
                    feed_a  <= '0;
                    feed_b  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl: a behavioural 3x3 MAC array closes the loop,
// a scoreboard checks results and cycle-stamped output snapshots.
module tb_systolic_mm_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [71:0] a_flat = '0;
    logic [71:0] b_flat = '0;
    logic        busy, done, mac_clr, mac_en;
    logic [23:0] feed_a, feed_b;
    logic [71:0] c_flat;
    logic [71:0] result_flat;

    systolic_mm_ctrl #(.DATA_W(8), .ACC_W(8), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .a_flat(a_flat), .b_flat(b_flat),
        .busy(busy), .done(done), .mac_clr(mac_clr), .mac_en(mac_en),
        .feed_a(feed_a), .feed_b(feed_b), .c_flat(c_flat), .result_flat(result_flat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output-stationary array: a flows right, b flows down.
    logic [7:0] ar [3][3];
    logic [7:0] br [3][3];
    logic [7:0] acc[3][3];
    always @(posedge clk) begin
        logic [7:0]  ai, bi;
        logic [15:0] prod;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (j == 0) ai = feed_a[8*i +: 8];
                else        ai = ar[i][j-1];
                if (i == 0) bi = feed_b[8*j +: 8];
                else        bi = br[i-1][j];
                prod = ai * bi;
                if (!reset || mac_clr) begin
                    ar[i][j]  <= 8'd0;
                    br[i][j]  <= 8'd0;
                    acc[i][j] <= 8'd0;
                end else begin
                    ar[i][j] <= ai;
                    br[i][j] <= bi;
                    if (mac_en) acc[i][j] <= acc[i][j] + prod[7:0];
                end
            end
        end
    end
    always_comb begin
        c_flat = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                c_flat[8*(3*i+j) +: 8] = acc[i][j];
    end

    typedef int mat_t [9];
    typedef struct { int cyc; logic [71:0] res; } done_t;
    typedef struct {
        int cyc; logic [23:0] fa; logic [23:0] fb; logic [3:0] ctl; bit chk_res; logic [71:0] res;
    } trace_t;

    done_t  done_q[$];
    trace_t trace_q[$];
    int pass_cnt = 0, total_cnt = 0, done_cnt = 0, runs_expected = 0, overlap = 0;

    mat_t M_SEQ     = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    mat_t M_ID      = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    mat_t M_ONE     = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    mat_t M_TWO     = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    mat_t M_THREE   = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    mat_t M_18      = '{18, 18, 18, 18, 18, 18, 18, 18, 18};
    mat_t M_16      = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
    mat_t M_ZERO    = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    mat_t M_ROWSUM  = '{6, 6, 6, 15, 15, 15, 24, 24, 24};
    mat_t M_COLSUM  = '{12, 15, 18, 12, 15, 18, 12, 15, 18};
    mat_t M_DIAG    = '{1, 0, 0, 0, 2, 0, 0, 0, 3};
    mat_t M_DIAGRES = '{1, 2, 3, 8, 10, 12, 21, 24, 27};

    function automatic logic [71:0] pack(input mat_t m);
        logic [71:0] p;
        for (int i = 0; i < 9; i++) p[8*i +: 8] = 8'(m[i]);
        return p;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_done(input int c, input mat_t r);
        done_t d;
        d.cyc = c; d.res = pack(r);
        done_q.push_back(d);
        runs_expected++;
    endtask

    // ctl = {busy, done, mac_clr, mac_en}
    task automatic push_tr(input int c, input logic [23:0] fa, input logic [23:0] fb,
                           input logic [3:0] ctl, input bit chk_res, input logic [71:0] res);
        trace_t t;
        t.cyc = c; t.fa = fa; t.fb = fb; t.ctl = ctl; t.chk_res = chk_res; t.res = res;
        trace_q.push_back(t);
    endtask

    // Issue a single-cycle start from a negedge; accepting edge makes cyc == x.
    task automatic issue(input mat_t a, input mat_t b, input mat_t r, input bit expect_done);
        int x;
        x = cyc + 1;
        a_flat = pack(a);
        b_flat = pack(b);
        start  = 1'b1;
        if (expect_done) push_done(x + 9, r);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compare against queued expectations whenever the DUT presents them.
    always @(negedge clk) begin
        if (mac_clr && mac_en) overlap++;
        if (done) begin
            done_t d;
            done_cnt++;
            if (done_q.size() == 0) begin
                chk($sformatf("spurious_done c%0d", cyc), 72'(done), 72'd0);
            end else begin
                d = done_q.pop_front();
                chk("done_cycle", 72'(cyc), 72'(d.cyc));
                for (int i = 0; i < 9; i++)
                    chk($sformatf("result[%0d] c%0d", i, cyc),
                        72'(result_flat[8*i +: 8]), 72'(d.res[8*i +: 8]));
            end
        end
        while (trace_q.size() > 0 && trace_q[0].cyc <= cyc) begin
            trace_t t;
            t = trace_q.pop_front();
            chk($sformatf("trace_cycle c%0d", t.cyc), 72'(cyc), 72'(t.cyc));
            chk($sformatf("feed_a c%0d", t.cyc), 72'(feed_a), 72'(t.fa));
            chk($sformatf("feed_b c%0d", t.cyc), 72'(feed_b), 72'(t.fb));
            chk($sformatf("busy_done_clr_en c%0d", t.cyc),
                72'({busy, done, mac_clr, mac_en}), 72'(t.ctl));
            if (t.chk_res) chk($sformatf("result_flat c%0d", t.cyc), result_flat, t.res);
        end
    end

    initial begin
        int x;
        logic [95:0] rnd;

        // Reset state
        push_tr(2, 24'h0, 24'h0, 4'b0000, 1'b1, 72'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: A=seq, B=identity, with feed trace and control timing
        x = cyc + 1;
        push_tr(x,     24'h000000, 24'h000000, 4'b1010, 1'b0, 72'h0);
        push_tr(x + 2, 24'h000402, 24'h000000, 4'b1001, 1'b0, 72'h0);
        push_tr(x + 5, 24'h090000, 24'h010000, 4'b1001, 1'b0, 72'h0);
        push_tr(x + 7, 24'h000000, 24'h000000, 4'b1001, 1'b0, 72'h0);
        push_tr(x + 8, 24'h000000, 24'h000000, 4'b1000, 1'b0, 72'h0);
        push_tr(x + 9, 24'h000000, 24'h000000, 4'b0100, 1'b0, 72'h0);
        push_tr(x + 10, 24'h000000, 24'h000000, 4'b0000, 1'b1, pack(M_SEQ));
        issue(M_SEQ, M_ID, M_SEQ, 1'b1);
        repeat (12) @(negedge clk);

        // 2: all 2 x all 3 = 18, with skew snapshots at steps 0 and 2
        x = cyc + 1;
        push_tr(x + 1, 24'h000002, 24'h000003, 4'b1001, 1'b0, 72'h0);
        push_tr(x + 3, 24'h020202, 24'h030303, 4'b1001, 1'b0, 72'h0);
        issue(M_TWO, M_THREE, M_18, 1'b1);
        repeat (12) @(negedge clk);

        // 3: modulo wrap, then identity to show the clear took effect
        issue(M_16, M_16, M_ZERO, 1'b1);
        repeat (12) @(negedge clk);
        issue(M_ID, M_ID, M_ID, 1'b1);
        repeat (12) @(negedge clk);

        // 4: start held high; second run accepted in the DONE cycle
        x = cyc + 1;
        push_done(x + 9, M_ROWSUM);
        push_done(x + 19, M_COLSUM);
        push_tr(x + 9,  24'h0, 24'h0, 4'b0100, 1'b1, pack(M_ROWSUM));
        push_tr(x + 10, 24'h0, 24'h0, 4'b1010, 1'b1, pack(M_ROWSUM));
        a_flat = pack(M_SEQ);
        b_flat = pack(M_ONE);
        start  = 1'b1;
        @(negedge clk);
        a_flat = pack(M_ONE);
        b_flat = pack(M_SEQ);
        while (cyc < x + 10) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // 5: reset pulse during FEED step 3 aborts without done
        x = cyc + 1;
        issue(M_SEQ, M_ID, M_SEQ, 1'b0);
        while (cyc < x + 4) @(negedge clk);
        push_tr(x + 5, 24'h0, 24'h0, 4'b0000, 1'b1, 72'h0);
        push_tr(x + 9, 24'h0, 24'h0, 4'b0000, 1'b1, 72'h0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        issue(M_ID, M_SEQ, M_SEQ, 1'b1);
        repeat (12) @(negedge clk);

        // 6: operand inputs scrambled every cycle after acceptance
        issue(M_DIAG, M_SEQ, M_DIAGRES, 1'b1);
        for (int k = 0; k < 11; k++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            a_flat = rnd[71:0];
            rnd = {$urandom(), $urandom(), $urandom()};
            b_flat = rnd[71:0];
            @(negedge clk);
        end
        repeat (4) @(negedge clk);

        chk("pending_done", 72'(done_q.size()), 72'd0);
        chk("pending_trace", 72'(trace_q.size()), 72'd0);
        chk("done_count", 72'(done_cnt), 72'(runs_expected));
        chk("clr_en_overlap", 72'(overlap), 72'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
